// File: rtl/fbuf_scanout_pkg.sv
// fbuf_scanout_pkg
//   Shared definitions for the framebuffer scan-out block:
//   - fsm_state_t      : scan-out run state (IDLE / RUN)
//   - DEF_*            : default 640x480@60 video timing constants
//   - rgb332_to_888()  : RGB332 -> RGB888 expansion by bit replication
package fbuf_scanout_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // 640x480@60 (25.175 MHz pixel clock) timing
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_FBUF_ADDR_WIDTH = 19;
  localparam int unsigned DEF_FBUF_DATA_WIDTH = 8;
  localparam int unsigned DEF_RD_LATENCY      = 2;

  // Input pixel is {R[2:0],G[2:0],B[1:0]}; output is {R8,G8,B8}.
  // Replication maps full-scale codes to 8'hFF and zero to 8'h00.
  function automatic logic [23:0] rgb332_to_888(input logic [7:0] pix);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = pix[7:5];
    g = pix[4:2];
    b = pix[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/fbuf_scanout_timing.sv
// vid_timing_gen
//   Raster counters and timing decode for one video mode. Knows nothing
//   about the framebuffer; all outputs are combinational decodes of the
//   current counter values (i.e. they describe the pixel being scanned
//   this clock) and are forced inactive while run is low.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   run         : counters advance while high, are held at 0 while low
//   active      : current pixel is inside the visible area
//   hsync_act   : current pixel is inside the horizontal sync window
//   vsync_act   : current line is inside the vertical sync window
//   sof         : current pixel is the first pixel of the frame
//   frame_end   : current pixel is the last clock of the frame
module vid_timing_gen
  import fbuf_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic active,
  output logic hsync_act,
  output logic vsync_act,
  output logic sof,
  output logic frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so the sync-end bound always fits
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Held at the origin while stopped, so the first RUN clock scans (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    active    = 1'b0;
    hsync_act = 1'b0;
    vsync_act = 1'b0;
    sof       = 1'b0;
    frame_end = 1'b0;
    if (run) begin
      active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hsync_act = (h_cnt >= HS_START) && (h_cnt < HS_END);
      vsync_act = (v_cnt >= VS_START) && (v_cnt < VS_END);
      sof       = (h_cnt == '0) && (v_cnt == '0);
      frame_end = h_last && v_last;
    end
  end

endmodule

// File: rtl/fbuf_scanout.sv
// fbuf_scanout
//   Scans a RGB332 framebuffer out of the read port of a dual-port BRAM
//   and produces VGA-style timed RGB888 video with hsync/vsync/de/sof
//   aligned to the pixel data. Single pixel-clock domain.
// Ports:
//   vid_aclk, vid_aresetn : pixel clock, asynchronous active-low reset
//   enable                : run request, sampled only at frame boundaries
//                           once running
//   fbuf_en_rd, fbuf_addr : registered BRAM read request
//   fbuf_data             : BRAM read data, valid RD_LATENCY clocks after
//                           the request
//   vid_hsync, vid_vsync  : syncs, polarity set by HSYNC_POL / VSYNC_POL
//   vid_de                : active-video data enable
//   vid_rgb               : {R8,G8,B8}, zero outside active video
//   vid_sof               : one-clock pulse with first active pixel
module fbuf_scanout
  import fbuf_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned H_FP            = DEF_H_FP,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BP            = DEF_H_BP,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter int unsigned V_FP            = DEF_V_FP,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BP            = DEF_V_BP,
  parameter bit          HSYNC_POL       = 1'b0,
  parameter bit          VSYNC_POL       = 1'b0,
  parameter int unsigned FBUF_ADDR_WIDTH = DEF_FBUF_ADDR_WIDTH,
  parameter int unsigned FBUF_DATA_WIDTH = DEF_FBUF_DATA_WIDTH,
  parameter int unsigned RD_LATENCY      = DEF_RD_LATENCY
) (
  input  logic                       vid_aclk,
  input  logic                       vid_aresetn,
  input  logic                       enable,
  output logic                       fbuf_en_rd,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  output logic                       vid_hsync,
  output logic                       vid_vsync,
  output logic                       vid_de,
  output logic [23:0]                vid_rgb,
  output logic                       vid_sof
);

  if (FBUF_DATA_WIDTH != 8) begin : g_bad_data_width
    $error("fbuf_scanout: FBUF_DATA_WIDTH must be 8 (RGB332)");
  end
  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("fbuf_scanout: RD_LATENCY must be at least 1");
  end

  fsm_state_t state;
  logic       run;
  logic       active;
  logic       hsync_act;
  logic       vsync_act;
  logic       sof;
  logic       frame_end;

  logic [FBUF_ADDR_WIDTH-1:0] addr_cnt;

  // Bit 0 is the stage launched together with the BRAM request; bit
  // RD_LATENCY lines up with fbuf_data arriving at the capture register.
  logic [RD_LATENCY:0] de_pipe;
  logic [RD_LATENCY:0] hs_pipe;
  logic [RD_LATENCY:0] vs_pipe;
  logic [RD_LATENCY:0] sof_pipe;

  assign run = (state == RUN);

  vid_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (vid_aclk),
    .rst_n     (vid_aresetn),
    .run       (run),
    .active    (active),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .sof       (sof),
    .frame_end (frame_end)
  );

  // Stopping is only honoured on the last clock of a frame, so a frame
  // once started is always scanned out completely.
  always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
    if (!vid_aresetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (frame_end && !enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Linear framebuffer: the address simply counts visible pixels and is
  // re-zeroed at the end of each frame.
  always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
    if (!vid_aresetn) begin
      addr_cnt <= '0;
    end else if (!run || frame_end) begin
      addr_cnt <= '0;
    end else if (active) begin
      addr_cnt <= addr_cnt + 1'b1;
    end
  end

  always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
    if (!vid_aresetn) begin
      fbuf_addr <= '0;
      de_pipe   <= '0;
      hs_pipe   <= '0;
      vs_pipe   <= '0;
      sof_pipe  <= '0;
    end else begin
      fbuf_addr <= addr_cnt;
      de_pipe   <= {de_pipe[RD_LATENCY-1:0],  active};
      hs_pipe   <= {hs_pipe[RD_LATENCY-1:0],  hsync_act};
      vs_pipe   <= {vs_pipe[RD_LATENCY-1:0],  vsync_act};
      sof_pipe  <= {sof_pipe[RD_LATENCY-1:0], sof};
    end
  end

  assign fbuf_en_rd = de_pipe[0];

  always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
    if (!vid_aresetn) begin
      vid_de    <= 1'b0;
      vid_sof   <= 1'b0;
      vid_hsync <= ~HSYNC_POL;
      vid_vsync <= ~VSYNC_POL;
      vid_rgb   <= '0;
    end else begin
      vid_de    <= de_pipe[RD_LATENCY];
      vid_sof   <= sof_pipe[RD_LATENCY];
      vid_hsync <= hs_pipe[RD_LATENCY] ? HSYNC_POL : ~HSYNC_POL;
      vid_vsync <= vs_pipe[RD_LATENCY] ? VSYNC_POL : ~VSYNC_POL;
      vid_rgb   <= de_pipe[RD_LATENCY] ? rgb332_to_888(fbuf_data) : '0;
    end
  end

endmodule

// File: tb/tb_fbuf_scanout.sv
// tb_fbuf_scanout
//   Bench for fbuf_scanout using a reduced video mode (16x9 total,
//   8x4 visible) so several full frames fit in a short run.
module tb_fbuf_scanout;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int L  = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        fbuf_en_rd;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;
  logic        vid_hsync;
  logic        vid_vsync;
  logic        vid_de;
  logic [23:0] vid_rgb;
  logic        vid_sof;

  always #5 clk = ~clk;

  fbuf_scanout #(
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .RD_LATENCY (L)
  ) dut (
    .vid_aclk    (clk),
    .vid_aresetn (rst_n),
    .enable      (enable),
    .fbuf_en_rd  (fbuf_en_rd),
    .fbuf_addr   (fbuf_addr),
    .fbuf_data   (fbuf_data),
    .vid_hsync   (vid_hsync),
    .vid_vsync   (vid_vsync),
    .vid_de      (vid_de),
    .vid_rgb     (vid_rgb),
    .vid_sof     (vid_sof)
  );

  // Framebuffer contents: a fixed 8-entry colour pattern repeating by address
  function automatic logic [7:0] pat(input int a);
    case (a % 8)
      0: return 8'hE0;
      1: return 8'h1C;
      2: return 8'h03;
      3: return 8'h92;
      4: return 8'h49;
      5: return 8'hFF;
      6: return 8'h00;
      default: return 8'hB6;
    endcase
  endfunction

  // BRAM read port with two clocks of latency
  logic [7:0] bram_d1 = '0;
  logic [7:0] bram_d2 = '0;
  always @(posedge clk) begin
    bram_d1 <= pat(int'(fbuf_addr));
    bram_d2 <= bram_d1;
  end
  assign fbuf_data = bram_d2;

  // Expected colour: each channel scaled to 0..255 with rounding
  function automatic logic [23:0] exp_rgb(input logic [7:0] p);
    int r, g, b;
    r = int'(p[7:5]);
    g = int'(p[4:2]);
    b = int'(p[1:0]);
    return {8'((r * 255 + 3) / 7), 8'((g * 255 + 3) / 7), 8'(b * 85)};
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          de;
    bit          hs;
    bit          vs;
    bit          sof;
    int          addr;
    logic [23:0] rgb;
  } rec_t;

  rec_t        ring [16];
  int unsigned cyc = 0;
  bit          m_run;
  int          pos;

  function automatic rec_t blank();
    rec_t r;
    r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.sof = 1'b0; r.addr = 0; r.rgb = '0;
    return r;
  endfunction

  // ring[n] describes the raster position scanned in the clock before edge n
  initial begin
    for (int i = 0; i < 16; i++) ring[i] = blank();
    m_run = 1'b0;
    pos = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) ring[i] = blank();
        m_run = 1'b0;
        pos = 0;
      end else begin
        rec_t r;
        int h, v;
        r = blank();
        if (m_run) begin
          h = pos % HT;
          v = pos / HT;
          if (h < HA && v < VA) begin
            r.de = 1'b1;
            r.addr = v * HA + h;
            r.rgb = exp_rgb(pat(r.addr));
          end
          if (h >= HA + HF && h < HA + HF + HS) r.hs = 1'b0;
          if (v >= VA + VF && v < VA + VF + VS) r.vs = 1'b0;
          r.sof = (pos == 0);
        end
        ring[cyc % 16] = r;
        cyc++;
        if (!m_run) begin
          if (enable) begin m_run = 1'b1; pos = 0; end
        end else begin
          pos++;
          if (pos == FRAME) begin
            pos = 0;
            if (!enable) m_run = 1'b0;
          end
        end
      end
    end
  end

  // Read request reflects the previous clock's scan; video lags by L+1 more
  always @(negedge clk) begin
    rec_t e0, ev;
    e0 = ring[(cyc + 15) % 16];
    ev = ring[(cyc + 16 - 1 - (L + 1)) % 16];
    check("en_rd", 64'(fbuf_en_rd), 64'(e0.de));
    if (e0.de) check("addr", 64'(fbuf_addr), 64'(e0.addr));
    check("de",    64'(vid_de),    64'(ev.de));
    check("hsync", 64'(vid_hsync), 64'(ev.hs));
    check("vsync", 64'(vid_vsync), 64'(ev.vs));
    check("sof",   64'(vid_sof),   64'(ev.sof));
    check("rgb",   64'(vid_rgb),   64'(ev.rgb));
  end

  // ---------------- directed sequence ----------------
  function automatic logic sig(input int id);
    case (id)
      0: return fbuf_en_rd;
      1: return vid_de;
      2: return vid_hsync;
      3: return vid_vsync;
      4: return vid_sof;
      default: return 1'b0;
    endcase
  endfunction

  localparam int S_EN = 0, S_DE = 1, S_HS = 2, S_VS = 3, S_SOF = 4;

  // Number of negedges until sig(id)==val; returns maxc on timeout
  task automatic wait_for(input int id, input logic val, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(id) !== val && n < maxc);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"},    64'(fbuf_en_rd), 64'(0));
    check({tag, "_addr"},  64'(fbuf_addr),  64'(0));
    check({tag, "_de"},    64'(vid_de),     64'(0));
    check({tag, "_sof"},   64'(vid_sof),    64'(0));
    check({tag, "_rgb"},   64'(vid_rgb),    64'(0));
    check({tag, "_hsync"}, 64'(vid_hsync),  64'(1));
    check({tag, "_vsync"}, 64'(vid_vsync),  64'(1));
  endtask

  task automatic start_and_check(input string tag);
    int n;
    wait_for(S_EN, 1'b1, 20, n);
    check({tag, "_first_rd_lat"}, 64'(n), 64'(2));
    check({tag, "_first_addr"}, 64'(fbuf_addr), 64'(0));
    wait_for(S_DE, 1'b1, 20, n);
    check({tag, "_de_lat"}, 64'(n), 64'(L + 1));
    check({tag, "_sof"}, 64'(vid_sof), 64'(1));
  endtask

  initial begin
    int n, m, cnt, maxa;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Start: first read at address 0, video L+1 clocks later with sof
    rst_n = 1'b1;
    enable = 1'b1;
    start_and_check("start");
    check("px0_rgb", 64'(vid_rgb), 64'(24'hFF0000));
    @(negedge clk);
    check("px1_sof", 64'(vid_sof), 64'(0));
    check("px1_rgb", 64'(vid_rgb), 64'(24'h00FF00));
    @(negedge clk);
    check("px2_rgb", 64'(vid_rgb), 64'(24'h0000FF));
    @(negedge clk);
    check("px3_rgb", 64'(vid_rgb), 64'(24'h9292AA));
    wait_for(S_DE, 1'b0, 40, n);
    check("line_rest", 64'(n), 64'(HA - 3));
    check("blank_rgb", 64'(vid_rgb), 64'(24'h000000));

    // Horizontal timing
    wait_for(S_HS, 1'b0, 40, n);
    check("hs_after_de", 64'(n), 64'(HF));
    wait_for(S_HS, 1'b1, 40, n);
    check("hs_width", 64'(n), 64'(HS));
    wait_for(S_HS, 1'b0, 40, m);
    check("hs_period", 64'(n + m), 64'(HT));

    // Vertical timing and frame length
    wait_for(S_SOF, 1'b1, 400, n);
    wait_for(S_VS, 1'b0, 400, n);
    check("vs_start", 64'(n), 64'((VA + VF) * HT));
    wait_for(S_VS, 1'b1, 400, m);
    check("vs_width", 64'(m), 64'(VS * HT));
    wait_for(S_SOF, 1'b1, 400, cnt);
    check("frame_len", 64'(n + m + cnt), 64'(FRAME));

    // Reads per frame and last address over one frame-long window
    cnt = 0;
    maxa = -1;
    repeat (FRAME) begin
      @(negedge clk);
      if (fbuf_en_rd === 1'b1) begin
        cnt++;
        if (int'(fbuf_addr) > maxa) maxa = int'(fbuf_addr);
      end
    end
    check("reads_per_frame", 64'(cnt), 64'(HA * VA));
    check("last_addr", 64'(maxa), 64'(HA * VA - 1));

    // Stop mid-frame: the frame completes, then blank
    wait_for(S_SOF, 1'b1, 400, n);
    repeat (2 * HT) @(negedge clk);
    enable = 1'b0;
    cnt = (vid_de === 1'b1) ? 1 : 0;
    m = 0;
    repeat (400) begin
      @(negedge clk);
      if (vid_de === 1'b1) cnt++;
      if (vid_sof === 1'b1) m++;
    end
    check("stop_remaining_px", 64'(cnt), 64'((VA - 2) * HA));
    check("stop_no_sof", 64'(m), 64'(0));
    check("stop_de", 64'(vid_de), 64'(0));
    check("stop_hsync", 64'(vid_hsync), 64'(1));
    check("stop_vsync", 64'(vid_vsync), 64'(1));
    check("stop_en", 64'(fbuf_en_rd), 64'(0));

    // Restart
    enable = 1'b1;
    start_and_check("restart");

    // Asynchronous reset between clock edges, mid-line
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_and_check("after_rst");
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
